// File: rtl/amx_core_arbiter.sv
// amx_core_arbiter
//   Round-robin burst arbiter that shares the amx_core1 nibble input between
//   two requesters. It grants one port per burst and zero-extends each
//   accepted nibble to 8 bits with one cycle of latency. After every burst or
//   abort it inserts a flush gap. A burst that stalls is aborted on timeout.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   req0/data0/last0     port 0 beat valid, nibble, final-beat marker
//   req1/data1/last1     port 1 beat valid, nibble, final-beat marker
//   gnt0, gnt1           registered grants (mutually exclusive)
//   core_data/core_valid registered beat toward the core ({4'h0,nibble} or 0)
//   burst_done, abort    1-cycle end-of-burst pulses (normal / timeout)
//   burst_cnt            completed bursts, saturating at 8'hFF
module amx_core_arbiter #(
  parameter int MAX_BURST  = 8,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic [3:0] data0,
  input  logic       last0,
  input  logic       req1,
  input  logic [3:0] data1,
  input  logic       last1,
  output logic       gnt0,
  output logic       gnt1,
  output logic [7:0] core_data,
  output logic       core_valid,
  output logic       burst_done,
  output logic       abort,
  output logic [7:0] burst_cnt
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_GRANT0, S_GRANT1, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic            rr_last_q, rr_last_d;
  logic [7:0]      burst_cnt_q, burst_cnt_d;
  logic [7:0]      core_data_q, core_data_d;
  logic            core_valid_q, core_valid_d;
  logic            burst_done_q, burst_done_d;
  logic            abort_q, abort_d;

  // Granted-port view: mux the owning port's signals onto one set.
  logic            in_grant, gnt_port, req_g, last_g;
  logic [3:0]      data_g;
  logic            accept, beat_end, to_end;

  always_comb begin
    in_grant = (state_q == S_GRANT0) || (state_q == S_GRANT1);
    gnt_port = (state_q == S_GRANT1);
    req_g    = gnt_port ? req1  : req0;
    last_g   = gnt_port ? last1 : last0;
    data_g   = gnt_port ? data1 : data0;
    accept   = in_grant & req_g;
    // last and the MAX_BURST-th beat on the same cycle collapse into one end.
    beat_end = accept & (last_g | (beat_cnt_q == BEAT_LAST));
    to_end   = in_grant & ~req_g & (to_cnt_q == TO_LAST);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req0 & req1)  state_d = rr_last_q ? S_GRANT0 : S_GRANT1;
        else if (req0)    state_d = S_GRANT0;
        else if (req1)    state_d = S_GRANT1;
      end
      S_GRANT0, S_GRANT1: begin
        if (beat_end | to_end) state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    gnt0 = (state_q == S_GRANT0);
    gnt1 = (state_q == S_GRANT1);
  end

  // Counters, round-robin pointer and registered core-side beat
  always_comb begin
    beat_cnt_d   = beat_cnt_q;
    to_cnt_d     = to_cnt_q;
    gap_cnt_d    = '0;
    rr_last_d    = rr_last_q;
    burst_cnt_d  = burst_cnt_q;
    core_valid_d = accept;
    core_data_d  = accept ? {4'h0, data_g} : 8'h00;
    burst_done_d = beat_end;
    abort_d      = to_end;

    // IDLE always precedes a grant, so clearing here covers every grant entry.
    if (state_q == S_IDLE) begin
      beat_cnt_d = '0;
      to_cnt_d   = '0;
    end else if (accept) begin
      beat_cnt_d = beat_cnt_q + BW'(1);
      to_cnt_d   = '0;
    end else if (in_grant) begin
      to_cnt_d   = to_cnt_q + TW'(1);
    end

    if (state_q == S_GAP) gap_cnt_d = gap_cnt_q + GW'(1);

    if (beat_end | to_end) rr_last_d = gnt_port;
    if (beat_end && (burst_cnt_q != 8'hFF)) burst_cnt_d = burst_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt_q   <= '0;
      to_cnt_q     <= '0;
      gap_cnt_q    <= '0;
      rr_last_q    <= 1'b1;
      burst_cnt_q  <= 8'h00;
      core_data_q  <= 8'h00;
      core_valid_q <= 1'b0;
      burst_done_q <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      beat_cnt_q   <= beat_cnt_d;
      to_cnt_q     <= to_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      rr_last_q    <= rr_last_d;
      burst_cnt_q  <= burst_cnt_d;
      core_data_q  <= core_data_d;
      core_valid_q <= core_valid_d;
      burst_done_q <= burst_done_d;
      abort_q      <= abort_d;
    end
  end

  assign core_data  = core_data_q;
  assign core_valid = core_valid_q;
  assign burst_done = burst_done_q;
  assign abort      = abort_q;
  assign burst_cnt  = burst_cnt_q;

endmodule

// File: tb/tb_amx_core_arbiter.sv
module tb_amx_core_arbiter;
  localparam int MAXB = 8;
  localparam int GAPC = 2;
  localparam int TMO  = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, last0 = 1'b0, req1 = 1'b0, last1 = 1'b0;
  logic [3:0] data0 = 4'h0, data1 = 4'h0;
  logic       gnt0, gnt1, core_valid, burst_done, abort;
  logic [7:0] core_data, burst_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  amx_core_arbiter #(.MAX_BURST(MAXB), .GAP_CYCLES(GAPC), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .data0(data0), .last0(last0),
    .req1(req1), .data1(data1), .last1(last1),
    .gnt0(gnt0), .gnt1(gnt1),
    .core_data(core_data), .core_valid(core_valid),
    .burst_done(burst_done), .abort(abort), .burst_cnt(burst_cnt)
  );

  // Reference model: owner -1 = nobody, 0/1 = that port, 2 = flush gap.
  int         m_own = -1, m_beats = 0, m_stall = 0, m_gap = 0, m_rr = 1;
  logic [7:0] m_data = 8'h00, m_cnt = 8'h00;
  logic       m_valid = 1'b0, m_done = 1'b0, m_abort = 1'b0;

  task automatic end_burst();
    m_rr = m_own;
    if (GAPC == 0) m_own = -1;
    else begin m_own = 2; m_gap = GAPC; end
  endtask

  task automatic model_edge(input bit r, input bit a0, input logic [3:0] d0, input bit l0,
                            input bit a1, input logic [3:0] d1, input bit l1);
    bit rq, l;
    logic [3:0] d;
    if (!r) begin
      m_own = -1; m_beats = 0; m_stall = 0; m_gap = 0; m_rr = 1;
      m_data = 8'h00; m_valid = 0; m_done = 0; m_abort = 0; m_cnt = 8'h00;
      return;
    end
    m_data = 8'h00; m_valid = 0; m_done = 0; m_abort = 0;
    if (m_own == -1) begin
      if (a0 && a1)  m_own = (m_rr == 0) ? 1 : 0;
      else if (a0)   m_own = 0;
      else if (a1)   m_own = 1;
      m_beats = 0; m_stall = 0;
    end else if (m_own == 0 || m_own == 1) begin
      rq = (m_own == 0) ? a0 : a1;
      l  = (m_own == 0) ? l0 : l1;
      d  = (m_own == 0) ? d0 : d1;
      if (rq) begin
        m_valid = 1; m_data = {4'h0, d}; m_beats++; m_stall = 0;
        if (l || m_beats == MAXB) begin
          m_done = 1;
          if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
          end_burst();
        end
      end else begin
        m_stall++;
        if (m_stall == TMO) begin m_abort = 1; end_burst(); end
      end
    end else begin
      m_gap--;
      if (m_gap == 0) m_own = -1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("gnt0",       gnt0,       (m_own == 0));
    check("gnt1",       gnt1,       (m_own == 1));
    check("core_data",  core_data,  m_data);
    check("core_valid", core_valid, m_valid);
    check("burst_done", burst_done, m_done);
    check("abort",      abort,      m_abort);
    check("burst_cnt",  burst_cnt,  m_cnt);
    check("gnt_mutex",  gnt0 & gnt1, 0);
  endtask

  task automatic step();
    bit r = rst_n, a0 = req0, l0 = last0, a1 = req1, l1 = last1;
    logic [3:0] d0 = data0, d1 = data1;
    @(posedge clk);
    model_edge(r, a0, d0, l0, a1, d1, l1);
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    req0 = 0; last0 = 0; req1 = 0; last1 = 0;
  endtask

  initial begin
    logic [7:0] vq[$];
    int order[$];
    int dones, n, cnt_before, aborts, nvalid;
    bit p0, p1;

    // Reset
    rst_n = 0; step(); step();
    check("reset_cnt", burst_cnt, 8'h00);

    // 1: single port burst of 1,2,3 ending on last0
    rst_n = 1; req0 = 1; data0 = 4'h1; step();
    check("t1_gnt0", gnt0, 1);
    dones = 0;
    for (int i = 1; i <= 3; i++) begin
      data0 = 4'(i); last0 = (i == 3); step();
      if (core_valid) vq.push_back(core_data);
      if (burst_done) dones++;
    end
    check("t1_gnt_drop", gnt0, 0);
    idle_inputs();
    for (int i = 0; i < GAPC; i++) begin
      step();
      check("t1_gap_valid", core_valid, 0);
      check("t1_gap_gnt", gnt0 | gnt1, 0);
    end
    check("t1_nbeats", vq.size(), 3);
    check("t1_beat0", vq[0], 8'h01);
    check("t1_beat1", vq[1], 8'h02);
    check("t1_beat2", vq[2], 8'h03);
    check("t1_dones", dones, 1);
    check("t1_cnt", burst_cnt, 8'h01);

    // 2: tie from reset alternates 0,1,0
    rst_n = 0; step(); rst_n = 1;
    req0 = 1; req1 = 1; last0 = 1; last1 = 1; data0 = 4'h5; data1 = 4'hA;
    p0 = 0; p1 = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (gnt0 && !p0) order.push_back(0);
      if (gnt1 && !p1) order.push_back(1);
      p0 = gnt0; p1 = gnt1;
    end
    check("t2_ngrants", order.size() >= 3, 1);
    check("t2_first", order[0], 0);
    check("t2_second", order[1], 1);
    check("t2_third", order[2], 0);
    idle_inputs(); for (int i = 0; i < 4; i++) step();

    // 3: port 1 never signals last -> MAX_BURST cap
    req1 = 1; data1 = 4'hF; nvalid = 0; n = 0;
    while (n < 30) begin
      step(); n++;
      if (core_valid && core_data == 8'h0F) nvalid++;
      if (burst_done) break;
    end
    check("t3_done_seen", burst_done, 1);
    check("t3_nbeats", nvalid, MAXB);
    check("t3_gnt1_drop", gnt1, 0);
    idle_inputs(); for (int i = 0; i < 4; i++) step();

    // 4: timeout abort
    cnt_before = burst_cnt;
    req0 = 1; data0 = 4'h3; step();
    check("t4_gnt0", gnt0, 1);
    req0 = 0; n = 0;
    while (n < 40) begin
      step(); n++;
      if (abort) break;
    end
    check("t4_abort_at", n, TMO);
    check("t4_cnt_same", burst_cnt, cnt_before);
    check("t4_gnt0_drop", gnt0, 0);
    for (int i = 0; i < 4; i++) step();

    // 5: stalls shorter than TIMEOUT, total longer, must not abort
    aborts = 0; nvalid = 0;
    req0 = 1; data0 = 4'h7; step();
    step(); nvalid += core_valid;
    req0 = 0; for (int i = 0; i < 10; i++) begin step(); aborts += abort; nvalid += core_valid; end
    req0 = 1; data0 = 4'h8; step(); nvalid += core_valid;
    req0 = 0; for (int i = 0; i < 10; i++) begin step(); aborts += abort; nvalid += core_valid; end
    req0 = 1; last0 = 1; data0 = 4'h9; step(); nvalid += core_valid;
    check("t5_no_abort", aborts, 0);
    check("t5_nvalid", nvalid, 3);
    check("t5_done", burst_done, 1);
    idle_inputs(); for (int i = 0; i < 4; i++) step();

    // 6: reset during GRANT1
    req1 = 1; data1 = 4'h2; step();
    check("t6_gnt1", gnt1, 1);
    step();
    rst_n = 0; step();
    check("t6_rst_gnt1", gnt1, 0);
    check("t6_rst_valid", core_valid, 0);
    check("t6_rst_cnt", burst_cnt, 8'h00);
    rst_n = 1; req0 = 1; req1 = 1; step();
    check("t6_tie_port0", gnt0, 1);
    idle_inputs(); for (int i = 0; i < 30; i++) step();

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      req0  = ($urandom_range(0, 9) < 6);
      req1  = ($urandom_range(0, 9) < 6);
      last0 = ($urandom_range(0, 9) < 2);
      last1 = ($urandom_range(0, 9) < 2);
      data0 = 4'($urandom);
      data1 = 4'($urandom);
      if ($urandom_range(0, 99) < 3) begin req0 = 0; req1 = 0; end
      step();
    end
    // Long stall on a random grant to exercise timeout inside random context
    rst_n = 1; idle_inputs(); for (int i = 0; i < 6; i++) step();
    req1 = 1; step(); req1 = 0;
    for (int i = 0; i < TMO + 6; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
